dmg_timer: RTL and testbench
============================

DMG_TIMER -- requirements
Module: dmg_timer

Interface
REQ-001 clk  input  1  4 MHz system clock (same net as atal_4mhz); all state updates on rising edge.
REQ-002 nreset  input  1  asynchronous active-low reset; assertion clears all state immediately.
REQ-003 div  input  16  free-running system divider value, incremented once per clk by its owner.
REQ-004 sel  input  1  register window select, high for addresses FF05..FF07.
REQ-005 addr  input  2  low address bits: 01 TIMA, 10 TMA, 11 TAC; 00 is ignored.
REQ-006 cpu_wr  input  1  write strobe; sampled on rising clk when sel=1.
REQ-007 cpu_rd  input  1  read strobe.
REQ-008 wdata  input  8  CPU write data.
REQ-009 rdata  output  8  read data.
REQ-010 rdata_oe  output  1  high when sel&cpu_rd&addr!=00; the top level tristates d with this signal.
REQ-011 irq  output  1  timer interrupt request pulse for IF bit 2.

Function
REQ-012 TAC SHALL be 3 bits: [2] enable, [1:0] tap select. Reads return {5'b11111, TAC}.
REQ-013 Tap mux: 00->div[9], 01->div[3], 10->div[5], 11->div[7].
REQ-014 tick = registered(TAC[2] & tap) AND NOT (TAC[2] & tap) now: a falling edge of the gated tap.
REQ-015 TAC writes that drop the gated tap from 1 to 0 SHALL produce a tick (DMG glitch); this is deliberate and required.
REQ-016 On a tick with TIMA<FF, TIMA<=TIMA+1 on the same clk edge.
REQ-017 On a tick with TIMA=FF, TIMA<=00 and the FSM enters OVF.
REQ-018 FSM states: IDLE, OVF (4 clk, TIMA reads 00), RELOAD (1 clk).
REQ-019 OVF->RELOAD after the 4th clk; entering RELOAD loads TIMA<=TMA and asserts irq high for exactly that 1 clk.
REQ-020 RELOAD->IDLE unconditionally; ticks during OVF/RELOAD increment TIMA normally.
REQ-021 A TIMA write during OVF SHALL cancel the reload: TIMA<=wdata, FSM->IDLE, no irq.
REQ-022 A TIMA write during RELOAD SHALL be ignored; TIMA keeps TMA.
REQ-023 A TMA write during RELOAD SHALL update both TMA and TIMA with wdata.
REQ-024 A tick in the same clk as a TIMA write (IDLE): the write wins and the tick is dropped.
REQ-025 Read latency is 0: rdata is combinational from the current registers while rdata_oe=1; otherwise 00.
REQ-026 Writes with sel=0 or addr=00 SHALL have no effect.

Reset
REQ-027 nreset low SHALL force TIMA=00, TMA=00, TAC=000, FSM=IDLE, the edge register to 0, irq=0, and rdata_oe to follow its combinational definition.
REQ-028 Reset asserted during OVF SHALL abort the overflow with no irq, then or afterwards.
REQ-029 The first tick after reset release SHALL require a fresh falling edge; no tick is inferred from reset release.

Structure
REQ-030 Shared package dmg_timer_pkg SHALL hold the register offsets (TIMA=1, TMA=2, TAC=3), the FSM state enum, the OVF length (4) and the tap index table.
REQ-031 Sub-module dmg_timer_tick SHALL contain the tap mux and falling-edge detector; registers and FSM stay in dmg_timer.

Verification
REQ-032 Bench SHALL cover TAC=101, TIMA=00, run 64 clk -> TIMA=04, one increment per 16 clk.
REQ-033 Bench SHALL cover TIMA=FF, TMA=AB, TAC=101, next tick -> TIMA=00 for 4 clk, then AB, irq high exactly 1 clk.
REQ-034 Bench SHALL cover, in the same setup, a write TIMA=42 during the 2nd OVF clk -> TIMA=42, no irq, TMA not loaded.
REQ-035 Bench SHALL cover, in the RELOAD clk, a write TMA=77 -> TMA=77 and TIMA=77; a TIMA write in the RELOAD clk is ignored.
REQ-036 Bench SHALL cover TAC=100 with div[9]=1, then a write TAC=000 -> TIMA increments by exactly 1.
REQ-037 Bench SHALL cover nreset pulsed low during OVF -> all registers 00, irq never asserts, reads of FF07 return F8.

Source files
------------

// File: rtl/dmg_timer_pkg.sv
// Shared definitions for the DMG timer: register offsets, FSM states,
// overflow length and the divider tap table.
package dmg_timer_pkg;

    localparam logic [1:0] REG_TIMA = 2'b01;
    localparam logic [1:0] REG_TMA  = 2'b10;
    localparam logic [1:0] REG_TAC  = 2'b11;

    localparam int OVF_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OVF,
        ST_RELOAD
    } state_t;

    typedef struct packed {
        logic       en;
        logic [1:0] clk_sel;
    } tac_t;

    // Divider bit feeding the timer for each TAC clock select.
    localparam logic [3:0] TAP_IDX [4] = '{4'd9, 4'd3, 4'd5, 4'd7};

    function automatic logic tap_bit(input logic [15:0] d, input logic [1:0] clk_sel);
        return d[TAP_IDX[clk_sel]];
    endfunction

endpackage

// File: rtl/dmg_timer_if.sv
// CPU register window of the DMG timer (FF05..FF07).
interface dmg_timer_if;
    logic       sel;
    logic [1:0] addr;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdata_oe;

    modport master (
        output sel, addr, cpu_wr, cpu_rd, wdata,
        input  rdata, rdata_oe
    );

    modport slave (
        input  sel, addr, cpu_wr, cpu_rd, wdata,
        output rdata, rdata_oe
    );
endinterface

// File: rtl/dmg_timer_tick.sv
// Selects the divider tap, gates it with the TAC enable and emits a tick
// on each falling edge of the gated tap, including edges caused by TAC writes.
module dmg_timer_tick
    import dmg_timer_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic [15:0] div,
    input  tac_t        tac,
    output logic        tick
);

    logic gated;
    logic gated_q;

    assign gated = tac.en & tap_bit(div, tac.clk_sel);

    // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            gated_q <= 1'b0;
        end else begin
            gated_q <= gated;
        end
    end

    // Clearing gated_q in reset means release can never look like a falling edge.
    assign tick = gated_q & ~gated;

endmodule

// File: rtl/dmg_timer.sv
// DMG timer registers (TIMA/TMA/TAC) with the delayed overflow reload FSM
// and the zero-latency CPU read path.
module dmg_timer
    import dmg_timer_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic [15:0] div,
    dmg_timer_if.slave  bus,
    output logic        irq
);

    localparam logic [1:0] OVF_LAST = 2'(OVF_LEN - 1);

    logic [7:0] tima;
    logic [7:0] tma;
    tac_t       tac;
    state_t     state;
    logic [1:0] ovf_cnt;
    logic       tick;

    logic       wr_en;
    logic       wr_tima;
    logic       wr_tma;
    logic       wr_tac;
    logic       rd_oe;
    logic [7:0] rdata_mux;

    dmg_timer_tick u_tick (
        .clk    (clk),
        .nreset (nreset),
        .div    (div),
        .tac    (tac),
        .tick   (tick)
    );

    assign wr_en   = bus.sel & bus.cpu_wr;
    assign wr_tima = wr_en & (bus.addr == REG_TIMA);
    assign wr_tma  = wr_en & (bus.addr == REG_TMA);
    assign wr_tac  = wr_en & (bus.addr == REG_TAC);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tima    <= 8'h00;
            tma     <= 8'h00;
            tac     <= '0;
            state   <= ST_IDLE;
            ovf_cnt <= 2'd0;
            irq     <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (wr_tma) tma <= bus.wdata;
            if (wr_tac) tac <= tac_t'(bus.wdata[2:0]);

            case (state)
                ST_IDLE: begin
                    // A CPU write to TIMA takes priority over a coincident tick.
                    if (wr_tima) begin
                        tima <= bus.wdata;
                    end else if (tick) begin
                        if (tima == 8'hFF) begin
                            tima    <= 8'h00;
                            ovf_cnt <= 2'd0;
                            state   <= ST_OVF;
                        end else begin
                            tima <= tima + 8'd1;
                        end
                    end
                end

                ST_OVF: begin
                    if (wr_tima) begin
                        tima  <= bus.wdata;
                        state <= ST_IDLE;
                    end else if (ovf_cnt == OVF_LAST) begin
                        tima  <= tma;
                        irq   <= 1'b1;
                        state <= ST_RELOAD;
                    end else begin
                        ovf_cnt <= ovf_cnt + 2'd1;
                        if (tick) tima <= tima + 8'd1;
                    end
                end

                ST_RELOAD: begin
                    // TIMA writes are dropped here; TMA writes pass through to TIMA.
                    state <= ST_IDLE;
                    if (wr_tma) begin
                        tima <= bus.wdata;
                    end else if (tick) begin
                        tima <= tima + 8'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rd_oe = bus.sel & bus.cpu_rd & (bus.addr != 2'b00);

    // NOTE: default assignment first so no path through the block infers a latch.
    always_comb begin
        rdata_mux = 8'h00;
        if (rd_oe) begin
            case (bus.addr)
                REG_TIMA: rdata_mux = tima;
                REG_TMA:  rdata_mux = tma;
                REG_TAC:  rdata_mux = {5'b11111, tac};
                default:  rdata_mux = 8'h00;
            endcase
        end
    end

    assign bus.rdata    = rdata_mux;
    assign bus.rdata_oe = rd_oe;

endmodule

// File: tb/tb_dmg_timer.sv
// Scoreboard bench for dmg_timer: stimulus queues expected read data,
// a negedge monitor compares whenever rdata_oe is presented.
module tb_dmg_timer;
    import dmg_timer_pkg::*;

    typedef struct {
        string      name;
        logic [7:0] data;
        int         irq_lvl;
        int         irqs;
    } exp_t;

    logic        clk;
    logic        nreset;
    logic [15:0] div;
    logic        irq;

    dmg_timer_if bus ();

    dmg_timer dut (
        .clk    (clk),
        .nreset (nreset),
        .div    (div),
        .bus    (bus),
        .irq    (irq)
    );

    exp_t sb_q[$];
    int   checks;
    int   failures;
    int   irq_seen;
    bit   tb_done;
    bit   mon_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts irq cycles and scores every presented read.
    initial begin
        checks   = 0;
        failures = 0;
        irq_seen = 0;
        mon_done = 1'b0;
        forever begin
            @(negedge clk);
            if (irq === 1'b1) irq_seen++;
            if (bus.rdata_oe === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got rdata %0h with no read queued", bus.rdata);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check(e.name, {24'h0, bus.rdata}, {24'h0, e.data});
                    if (e.irq_lvl >= 0) check({e.name, "_irq"}, {31'h0, irq}, e.irq_lvl);
                    if (e.irqs >= 0) begin
                        check({e.name, "_irqs"}, irq_seen, e.irqs);
                        irq_seen = 0;
                    end
                end
            end else begin
                check("rdata_idle", {24'h0, bus.rdata}, 32'h0);
            end
            if (tb_done && !mon_done) begin
                check("sb_drained", sb_q.size(), 0);
                mon_done = 1'b1;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        div = div + 16'd1;
    endtask

    task automatic bus_idle();
        bus.sel    = 1'b0;
        bus.addr   = 2'b00;
        bus.cpu_wr = 1'b0;
        bus.cpu_rd = 1'b0;
        bus.wdata  = 8'h00;
    endtask

    task automatic wr(input logic s, input logic [1:0] a, input logic [7:0] d);
        bus.sel    = s;
        bus.addr   = a;
        bus.cpu_wr = 1'b1;
        bus.wdata  = d;
        cycle();
        bus_idle();
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [7:0] exp,
                      input int irq_lvl = -1, input int irqs = -1);
        exp_t e;
        e.name    = name;
        e.data    = exp;
        e.irq_lvl = irq_lvl;
        e.irqs    = irqs;
        sb_q.push_back(e);
        bus.sel    = 1'b1;
        bus.addr   = a;
        bus.cpu_rd = 1'b1;
        cycle();
        bus_idle();
    endtask

    // Leaves the bench at the first OVF clk (div=17) with TMA=tma_v.
    task automatic arm_overflow(input logic [7:0] tma_v);
        wr(1'b1, REG_TAC, 8'h00);
        wr(1'b1, REG_TIMA, 8'hFF);
        wr(1'b1, REG_TMA, tma_v);
        div = 16'h0000;
        wr(1'b1, REG_TAC, 8'h05);
        repeat (15) cycle();
        rd("arm_pre_ff", REG_TIMA, 8'hFF);
    endtask

    initial begin
        tb_done = 1'b0;
        nreset  = 1'b0;
        div     = 16'h0000;
        bus_idle();
        @(posedge clk);
        #1;

        // Reset state, read while reset is held and after release.
        rd("rst_in_tima", REG_TIMA, 8'h00);
        nreset = 1'b1;
        rd("rst_tima", REG_TIMA, 8'h00);
        rd("rst_tma", REG_TMA, 8'h00);
        rd("rst_tac", REG_TAC, 8'hF8, 0, 0);

        // Writes without sel or to offset 00 are ignored; offset 00 reads stay off the bus.
        wr(1'b0, REG_TIMA, 8'h99);
        wr(1'b1, 2'b00, 8'h99);
        bus.sel = 1'b1; bus.cpu_rd = 1'b1; bus.addr = 2'b00;
        cycle();
        bus_idle();
        rd("nosel_tima", REG_TIMA, 8'h00);
        wr(1'b1, REG_TMA, 8'h5A);
        rd("tma_rw", REG_TMA, 8'h5A);

        // TAC=101: one increment per 16 clk, 4 in 64 clk.
        wr(1'b1, REG_TIMA, 8'h00);
        div = 16'h0000;
        wr(1'b1, REG_TAC, 8'h05);
        rd("tac_rd", REG_TAC, 8'hFD);
        repeat (15) cycle();
        rd("cnt_16", REG_TIMA, 8'h01);
        repeat (47) cycle();
        rd("cnt_64", REG_TIMA, 8'h04);

        // TIMA write in the tick clk wins over the tick.
        repeat (14) cycle();
        wr(1'b1, REG_TIMA, 8'h20);
        rd("wr_beats_tick", REG_TIMA, 8'h20);

        // Overflow: 4 clk of 00, then TMA with a 1-clk irq.
        arm_overflow(8'hAB);
        rd("ovf_0", REG_TIMA, 8'h00);
        rd("ovf_1", REG_TIMA, 8'h00);
        rd("ovf_2", REG_TIMA, 8'h00);
        rd("ovf_3", REG_TIMA, 8'h00, 0);
        rd("reload", REG_TIMA, 8'hAB, 1);
        rd("post_reload", REG_TIMA, 8'hAB, 0, 1);

        // TIMA write in the 2nd OVF clk cancels the reload.
        arm_overflow(8'hAB);
        rd("cancel_ovf0", REG_TIMA, 8'h00);
        wr(1'b1, REG_TIMA, 8'h42);
        rd("cancel_a", REG_TIMA, 8'h42);
        rd("cancel_b", REG_TIMA, 8'h42);
        rd("cancel_c", REG_TIMA, 8'h42, 0);
        rd("cancel_d", REG_TIMA, 8'h42, 0, 0);

        // TMA write in the RELOAD clk reaches both TMA and TIMA.
        arm_overflow(8'hAB);
        repeat (4) cycle();
        wr(1'b1, REG_TMA, 8'h77);
        rd("rl_tma_tima", REG_TIMA, 8'h77);
        rd("rl_tma_tma", REG_TMA, 8'h77, -1, 1);

        // TIMA write in the RELOAD clk is ignored.
        arm_overflow(8'h3C);
        repeat (4) cycle();
        wr(1'b1, REG_TIMA, 8'h55);
        rd("rl_tima_ign", REG_TIMA, 8'h3C);
        rd("rl_tima_tma", REG_TMA, 8'h3C, -1, 1);

        // Disabling TAC while the div[9] tap is high ticks exactly once.
        wr(1'b1, REG_TAC, 8'h00);
        wr(1'b1, REG_TIMA, 8'h10);
        div = 16'h0200;
        wr(1'b1, REG_TAC, 8'h04);
        cycle();
        wr(1'b1, REG_TAC, 8'h00);
        rd("glitch_pre", REG_TIMA, 8'h10);
        rd("glitch_tick", REG_TIMA, 8'h11);
        repeat (20) cycle();
        rd("glitch_once", REG_TIMA, 8'h11);

        // Reset in the 2nd OVF clk aborts the overflow with no irq.
        arm_overflow(8'hAB);
        cycle();
        nreset = 1'b0;
        rd("rst_ovf_tma", REG_TMA, 8'h00);
        rd("rst_ovf_tac", REG_TAC, 8'hF8);
        rd("rst_ovf_tima", REG_TIMA, 8'h00);
        nreset = 1'b1;
        repeat (20) cycle();
        rd("rst_after_tima", REG_TIMA, 8'h00);
        rd("rst_after_tma", REG_TMA, 8'h00);
        rd("rst_after_tac", REG_TAC, 8'hF8, 0, 0);

        tb_done = 1'b1;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
